// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states, ALU ops,
// opcode/funct constants, datapath mux selects and the per-state control bundle.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_JALR     = 4'd14
    } state_t;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
        ALU_OR  = 4'd4, ALU_XOR = 4'd5, ALU_NOR = 4'd6, ALU_SLT = 4'd7,
        ALU_SLL = 4'd8, ALU_SRL = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {PCS_ALU, PCS_ALUOUT, PCS_JUMP, PCS_RS} pc_source_t;
    typedef enum logic [1:0] {SRCB_B, SRCB_4, SRCB_IMM, SRCB_IMM_SH} alu_src_b_t;
    typedef enum logic [1:0] {RD_RT, RD_RD, RD_R31} reg_dst_t;
    typedef enum logic [1:0] {M2R_ALU, M2R_MDR, M2R_PC} mem_to_reg_t;

    typedef enum logic [3:0] {
        CL_ILLEGAL, CL_R, CL_I, CL_MEM, CL_BR, CL_J, CL_JAL, CL_JR, CL_JALR
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        mem_half;
        logic        iord;
        logic        ir_write;
        logic        mdr_write;
        logic        pc_write;
        pc_source_t  pc_source;
        logic        alu_src_a;
        alu_src_b_t  alu_src_b;
        alu_op_t     alu_op;
        logic        reg_write;
        reg_dst_t    reg_dst;
        mem_to_reg_t mem_to_reg;
        logic        illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Unified instruction/data memory request channel with ready handshake.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_half;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, mem_we, mem_half, iord, input mem_ready);
    modport slave  (input mem_req, mem_we, mem_half, iord, output mem_ready);
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to class, ALU op and access size.
module mc_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    cls,
    output alu_op_t    alu_op_r,
    output alu_op_t    alu_op_i,
    output logic       is_load,
    output logic       is_half,
    output logic       illegal
);
    always_comb begin
        cls      = CL_ILLEGAL;
        alu_op_r = ALU_NOP;
        alu_op_i = ALU_NOP;
        is_load  = 1'b0;
        is_half  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                cls = CL_R;
                case (funct)
                    FN_ADD:  alu_op_r = ALU_ADD;
                    FN_SUB:  alu_op_r = ALU_SUB;
                    FN_AND:  alu_op_r = ALU_AND;
                    FN_OR:   alu_op_r = ALU_OR;
                    FN_XOR:  alu_op_r = ALU_XOR;
                    FN_NOR:  alu_op_r = ALU_NOR;
                    FN_SLT:  alu_op_r = ALU_SLT;
                    FN_SLL:  alu_op_r = ALU_SLL;
                    FN_SRL:  alu_op_r = ALU_SRL;
                    FN_JR:   cls = CL_JR;
                    FN_JALR: cls = CL_JALR;
                    default: cls = CL_ILLEGAL;
                endcase
            end
            OP_ADDI: begin cls = CL_I; alu_op_i = ALU_ADD; end
            OP_ANDI: begin cls = CL_I; alu_op_i = ALU_AND; end
            OP_SLTI: begin cls = CL_I; alu_op_i = ALU_SLT; end
            OP_LW:   begin cls = CL_MEM; is_load = 1'b1; end
            OP_LH:   begin cls = CL_MEM; is_load = 1'b1; is_half = 1'b1; end
            OP_SW:   cls = CL_MEM;
            OP_SH:   begin cls = CL_MEM; is_half = 1'b1; end
            OP_BEQ,
            OP_BNE:  cls = CL_BR;
            OP_J:    cls = CL_J;
            OP_JAL:  cls = CL_JAL;
            default: cls = CL_ILLEGAL;
        endcase
    end

    assign illegal = (cls == CL_ILLEGAL);
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer: per-state mux selects, register enables and memory
// requests for a shared-ALU, single-memory MIPS-subset datapath.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [5:0]                     opcode,
    input  logic [5:0]                     funct,
    input  logic                           zero,
    multicycle_controller_if.master        mem,
    output logic                           ir_write,
    output logic                           mdr_write,
    output logic                           pc_write,
    output logic [1:0]                     pc_source,
    output logic                           alu_src_a,
    output logic [1:0]                     alu_src_b,
    output logic [3:0]                     alu_op,
    output logic                           reg_write,
    output logic [1:0]                     reg_dst,
    output logic [1:0]                     mem_to_reg,
    output logic                           illegal,
    output logic [3:0]                     state
);
    state_t  state_q, state_d;
    ctrl_t   ctrl, ctrl_o;
    iclass_t cls;
    alu_op_t alu_op_r, alu_op_i;
    logic    is_load, is_half, dec_illegal;

    mc_decode u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .cls      (cls),
        .alu_op_r (alu_op_r),
        .alu_op_i (alu_op_i),
        .is_load  (is_load),
        .is_half  (is_half),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RESET_STATE;
        else        state_q <= state_d;
    end

    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALU_ADD;
                if (mem.mem_ready) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCS_ALU;
                    state_d        = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut while the class resolves.
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
                if (dec_illegal) begin
                    ctrl.illegal = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    case (cls)
                        CL_R:    state_d = S_EXEC_R;
                        CL_I:    state_d = S_EXEC_I;
                        CL_MEM:  state_d = S_MEM_ADDR;
                        CL_BR:   state_d = S_BRANCH;
                        CL_J:    state_d = S_JUMP;
                        CL_JAL:  state_d = S_JAL;
                        CL_JR:   state_d = S_JR;
                        CL_JALR: state_d = S_JALR;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = alu_op_r;
                state_d        = S_WB_R;
            end
            S_WB_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = RD_RD;
                state_d        = S_FETCH;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = alu_op_i;
                state_d        = S_WB_I;
            end
            S_WB_I: begin
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_d        = is_load ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.mem_half = is_half;
                if (mem.mem_ready) begin
                    ctrl.mdr_write = 1'b1;
                    state_d        = S_WB_MEM;
                end
            end
            S_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_MDR;
                state_d         = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.mem_we   = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.mem_half = is_half;
                if (mem.mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCS_ALUOUT;
                ctrl.pc_write  = (opcode == OP_BNE) ? ~zero : zero;
                state_d        = S_FETCH;
            end
            S_JUMP, S_JAL: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
                if (state_q == S_JAL) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = RD_R31;
                    ctrl.mem_to_reg = M2R_PC;
                end
                state_d = S_FETCH;
            end
            S_JR, S_JALR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_RS;
                if (state_q == S_JALR) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = RD_RD;
                    ctrl.mem_to_reg = M2R_PC;
                end
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are forced low combinationally so a request dies the instant reset asserts.
    assign ctrl_o = rst_n ? ctrl : '0;

    assign mem.mem_req  = ctrl_o.mem_req;
    assign mem.mem_we   = ctrl_o.mem_we;
    assign mem.mem_half = ctrl_o.mem_half;
    assign mem.iord     = ctrl_o.iord;
    assign ir_write     = ctrl_o.ir_write;
    assign mdr_write    = ctrl_o.mdr_write;
    assign pc_write     = ctrl_o.pc_write;
    assign pc_source    = ctrl_o.pc_source;
    assign alu_src_a    = ctrl_o.alu_src_a;
    assign alu_src_b    = ctrl_o.alu_src_b;
    assign alu_op       = ctrl_o.alu_op;
    assign reg_write    = ctrl_o.reg_write;
    assign reg_dst      = ctrl_o.reg_dst;
    assign mem_to_reg   = ctrl_o.mem_to_reg;
    assign illegal      = ctrl_o.illegal;
    assign state        = rst_n ? state_q : 4'd0;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-cycle expected control vectors queued per instruction, checked each cycle.
module tb_multicycle_controller;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_we, mem_half, iord, ir_write, mdr_write, pc_write;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       illegal;
    } obs_t;

    typedef struct {
        obs_t  o;
        logic  rdy;
        string tag;
    } step_t;

    localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LD = 3, C_ST = 4, C_BR = 5,
                   C_J = 6, C_JAL = 7, C_JR = 8, C_JALR = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0;
    logic       ir_write, mdr_write, pc_write, alu_src_a, reg_write, illegal;
    logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
    logic [3:0] alu_op, state;
    obs_t       act;
    step_t      sb[$];
    int         total = 0, bad = 0;

    multicycle_controller_if mif();

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem        (mif),
        .ir_write   (ir_write),
        .mdr_write  (mdr_write),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    assign act = {state, mif.mem_req, mif.mem_we, mif.mem_half, mif.iord, ir_write, mdr_write,
                  pc_write, pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
                  mem_to_reg, illegal};

    task automatic chk(string tag, obs_t got, obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic obs_t mk(int st);
        obs_t o = '0;
        o.st = st[3:0];
        return o;
    endfunction

    task automatic push(string tag, logic rdy, obs_t o);
        step_t s;
        s.o = o; s.rdy = rdy; s.tag = tag;
        sb.push_back(s);
    endtask

    function automatic obs_t fetch_obs(logic rdy);
        obs_t o = mk(0);
        o.mem_req = 1'b1; o.alu_src_b = 2'd1; o.alu_op = 4'd1;
        o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction

    // Drive each queued step's mem_ready after the edge, compare mid-cycle.
    task automatic run_sb();
        step_t s;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            mif.mem_ready = s.rdy;
            @(negedge clk);
            chk(s.tag, act, s.o);
            @(posedge clk); #1;
        end
    endtask

    task automatic instr(string nm, logic [5:0] op, logic [5:0] fn, logic z, int fw, int mw);
        obs_t o;
        int   k = C_ILL;
        logic [3:0] aop = 4'd0;
        logic half = 1'b0, is_bne = 1'b0;
        case (op)
            6'h00: case (fn)
                6'h20: begin k = C_R; aop = 4'd1; end
                6'h22: begin k = C_R; aop = 4'd2; end
                6'h24: begin k = C_R; aop = 4'd3; end
                6'h25: begin k = C_R; aop = 4'd4; end
                6'h26: begin k = C_R; aop = 4'd5; end
                6'h27: begin k = C_R; aop = 4'd6; end
                6'h2A: begin k = C_R; aop = 4'd7; end
                6'h00: begin k = C_R; aop = 4'd8; end
                6'h02: begin k = C_R; aop = 4'd9; end
                6'h08: k = C_JR;
                6'h09: k = C_JALR;
                default: k = C_ILL;
            endcase
            6'h08: begin k = C_I; aop = 4'd1; end
            6'h0C: begin k = C_I; aop = 4'd3; end
            6'h0A: begin k = C_I; aop = 4'd7; end
            6'h23: k = C_LD;
            6'h21: begin k = C_LD; half = 1'b1; end
            6'h2B: k = C_ST;
            6'h29: begin k = C_ST; half = 1'b1; end
            6'h04: k = C_BR;
            6'h05: begin k = C_BR; is_bne = 1'b1; end
            6'h02: k = C_J;
            6'h03: k = C_JAL;
            default: k = C_ILL;
        endcase
        opcode = op; funct = fn; zero = z;
        for (int i = 0; i < fw; i++) push({nm, "_fetch_wait"}, 1'b0, fetch_obs(1'b0));
        push({nm, "_fetch"}, 1'b1, fetch_obs(1'b1));
        o = mk(1); o.alu_src_b = 2'd3; o.alu_op = 4'd1; o.illegal = (k == C_ILL);
        push({nm, "_decode"}, 1'b1, o);
        case (k)
            C_R, C_I: begin
                o = mk(k == C_R ? 2 : 4); o.alu_src_a = 1'b1;
                o.alu_src_b = (k == C_R) ? 2'd0 : 2'd2; o.alu_op = aop;
                push({nm, "_exec"}, 1'b1, o);
                o = mk(k == C_R ? 3 : 5); o.reg_write = 1'b1;
                o.reg_dst = (k == C_R) ? 2'd1 : 2'd0;
                push({nm, "_wb"}, 1'b1, o);
            end
            C_LD, C_ST: begin
                o = mk(6); o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_op = 4'd1;
                push({nm, "_addr"}, 1'b1, o);
                o = mk(k == C_LD ? 7 : 9); o.mem_req = 1'b1; o.iord = 1'b1;
                o.mem_half = half; o.mem_we = (k == C_ST);
                for (int i = 0; i < mw; i++) push({nm, "_mem_wait"}, 1'b0, o);
                o.mdr_write = (k == C_LD);
                push({nm, "_mem_done"}, 1'b1, o);
                if (k == C_LD) begin
                    o = mk(8); o.reg_write = 1'b1; o.mem_to_reg = 2'd1;
                    push({nm, "_wb"}, 1'b1, o);
                end
            end
            C_BR: begin
                o = mk(10); o.alu_src_a = 1'b1; o.alu_op = 4'd2; o.pc_source = 2'd1;
                o.pc_write = is_bne ? ~z : z;
                push({nm, "_branch"}, 1'b1, o);
            end
            C_J, C_JAL: begin
                o = mk(k == C_J ? 11 : 12); o.pc_write = 1'b1; o.pc_source = 2'd2;
                if (k == C_JAL) begin o.reg_write = 1'b1; o.reg_dst = 2'd2; o.mem_to_reg = 2'd2; end
                push({nm, "_jump"}, 1'b1, o);
            end
            C_JR, C_JALR: begin
                o = mk(k == C_JR ? 13 : 14); o.pc_write = 1'b1; o.pc_source = 2'd3;
                if (k == C_JALR) begin o.reg_write = 1'b1; o.reg_dst = 2'd1; o.mem_to_reg = 2'd2; end
                push({nm, "_jr"}, 1'b1, o);
            end
            default: ;
        endcase
        run_sb();
    endtask

    initial begin
        obs_t o;
        mif.mem_ready = 1'b1;
        #1;
        chk("reset_outputs", act, '0);
        mif.mem_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        instr("add",  6'h00, 6'h20, 1'b0, 0, 0);
        instr("sub",  6'h00, 6'h22, 1'b0, 0, 0);
        instr("nor",  6'h00, 6'h27, 1'b0, 0, 0);
        instr("slt",  6'h00, 6'h2A, 1'b0, 0, 0);
        instr("sll",  6'h00, 6'h00, 1'b0, 0, 0);
        instr("srl",  6'h00, 6'h02, 1'b0, 0, 0);
        instr("addi", 6'h08, 6'h11, 1'b0, 0, 0);
        instr("andi", 6'h0C, 6'h00, 1'b0, 0, 0);
        instr("slti", 6'h0A, 6'h00, 1'b0, 0, 0);
        instr("lw",   6'h23, 6'h00, 1'b0, 0, 2);
        instr("lh",   6'h21, 6'h00, 1'b0, 0, 0);
        instr("sw",   6'h2B, 6'h00, 1'b0, 1, 1);
        instr("sh",   6'h29, 6'h00, 1'b0, 0, 0);
        instr("beq1", 6'h04, 6'h00, 1'b1, 0, 0);
        instr("beq0", 6'h04, 6'h00, 1'b0, 0, 0);
        instr("bne1", 6'h05, 6'h00, 1'b1, 0, 0);
        instr("bne0", 6'h05, 6'h00, 1'b0, 0, 0);
        instr("j",    6'h02, 6'h00, 1'b0, 0, 0);
        instr("jal",  6'h03, 6'h00, 1'b0, 2, 0);
        instr("jr",   6'h00, 6'h08, 1'b0, 0, 0);
        instr("jalr", 6'h00, 6'h09, 1'b0, 0, 0);
        instr("ill_op", 6'h3F, 6'h00, 1'b0, 0, 0);
        instr("ill_fn", 6'h00, 6'h01, 1'b0, 0, 0);

        // sh stalled in MEM_WR, then reset asserted mid-access.
        opcode = 6'h29; funct = 6'h00;
        push("shr_fetch", 1'b1, fetch_obs(1'b1));
        o = mk(1); o.alu_src_b = 2'd3; o.alu_op = 4'd1; push("shr_decode", 1'b1, o);
        o = mk(6); o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_op = 4'd1; push("shr_addr", 1'b1, o);
        o = mk(9); o.mem_req = 1'b1; o.mem_we = 1'b1; o.iord = 1'b1; o.mem_half = 1'b1;
        push("shr_mem_wait", 1'b0, o);
        run_sb();
        mif.mem_ready = 1'b0;
        #2;
        chk("shr_mem_wait2", act, o);
        rst_n = 1'b0;
        #1;
        chk("shr_async_reset", act, '0);
        @(negedge clk); #1;
        chk("shr_reset_hold", act, '0);
        rst_n = 1'b1;
        #1;
        chk("shr_release_fetch", act, fetch_obs(1'b0));
        @(posedge clk); #1;

        instr("add_post", 6'h00, 6'h20, 1'b0, 0, 0);
        instr("lw_post",  6'h23, 6'h00, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
